// File: rtl/apb_requester.sv
// apb_requester: APB4 requester with completer decode, back-to-back issue, timeout and decode-miss reporting
module apb_requester #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int NUM_SLV = 4,
  parameter int SEL_LSB = 12,
  parameter int TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [ADDR_W-1:0]         cmd_addr,
  input  logic                      cmd_write,
  input  logic [DATA_W-1:0]         cmd_wdata,
  input  logic [DATA_W/8-1:0]       cmd_strb,
  input  logic [2:0]                cmd_prot,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic                      pwrite,
  output logic [2:0]                pprot,
  output logic [DATA_W-1:0]         pwdata,
  output logic [DATA_W/8-1:0]       pstrb,
  output logic [NUM_SLV-1:0]        psel,
  output logic                      penable,
  input  logic [NUM_SLV*DATA_W-1:0] prdata_flat,
  input  logic [NUM_SLV-1:0]        pready_vec,
  input  logic [NUM_SLV-1:0]        pslverr_vec
);
  localparam int IW = NUM_SLV > 1 ? $clog2(NUM_SLV) : 1;
  localparam int NP = 1 << IW;
  localparam int RW = NP * DATA_W;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DERR = 2'd3;
  logic [1:0] state;
  logic [IW-1:0] idx, idx_q;
  logic [CW-1:0] cnt;
  logic derr_late;
  logic [NP-1:0] rdy_p, err_p;
  logic [RW-1:0] rd_p;
  logic [DATA_W-1:0] rd;
  logic rdy, err, to_hit, done, acc, miss;
  // pad completer vectors to a power of two so any index value is in range
  assign rdy_p = NP'(pready_vec);
  assign err_p = NP'(pslverr_vec);
  assign rd_p = RW'(prdata_flat);
  assign idx = cmd_addr[SEL_LSB +: IW];
  assign rdy = rdy_p[idx_q];
  assign err = err_p[idx_q];
  assign rd = rd_p[idx_q*DATA_W +: DATA_W];
  // cnt holds ACCESS cycles already spent; the current one makes it cnt+1
  assign to_hit = (TIMEOUT > 0) && (int'(cnt) + 1 == TIMEOUT) && !rdy;
  assign done = (state == ACCESS) && rdy;
  assign cmd_ready = !preset && ((state == IDLE) || (done && !to_hit));
  assign acc = cmd_valid && cmd_ready;
  assign miss = int'(idx) >= NUM_SLV;
  always_ff @(posedge pclk) begin
    if (preset) begin
      state <= IDLE;
      idx_q <= '0;
      cnt <= '0;
      derr_late <= 1'b0;
      paddr <= '0;
      pwrite <= 1'b0;
      pprot <= '0;
      pwdata <= '0;
      pstrb <= '0;
      psel <= '0;
      penable <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_rdata <= '0;
      derr_late <= 1'b0;
      if (state == SETUP) begin
        state <= ACCESS;
        penable <= 1'b1;
      end
      if (state == ACCESS) begin
        cnt <= cnt + CW'(1);
        if (rdy || to_hit) begin
          state <= IDLE;
          psel <= '0;
          penable <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_err <= to_hit || err;
          rsp_rdata <= (pwrite || err || to_hit) ? '0 : rd;
        end
      end
      // a miss accepted behind a completion reports one cycle later to keep pulses distinct
      if (state == DERR) begin
        state <= IDLE;
        rsp_valid <= derr_late;
        rsp_err <= derr_late;
      end
      if (acc) begin
        state <= miss ? DERR : SETUP;
        idx_q <= idx;
        cnt <= '0;
        paddr <= cmd_addr;
        pwrite <= cmd_write;
        pprot <= cmd_prot;
        pwdata <= cmd_wdata;
        pstrb <= cmd_write ? cmd_strb : '0;
        psel <= miss ? '0 : NUM_SLV'(1) << idx;
        penable <= 1'b0;
        derr_late <= miss && (state == ACCESS);
        if (miss && state == IDLE) begin
          rsp_valid <= 1'b1;
          rsp_err <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_apb_requester.sv
// tb_apb_requester: directed checks of the APB requester, with a 3-completer instance for decode misses
module tb_apb_requester;
  logic pclk, preset;
  logic cmd_valid, cmd_valid3, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0] cmd_strb;
  logic [2:0] cmd_prot;
  logic [127:0] prdata;
  logic [3:0] pready, pslverr;
  logic [95:0] prdata3;
  logic [2:0] pready3, pslverr3;
  logic cmd_ready, rsp_valid, rsp_err, pwrite, penable;
  logic [31:0] rsp_rdata, paddr, pwdata;
  logic [2:0] pprot;
  logic [3:0] pstrb, psel;
  logic cmd_ready3, rsp_valid3, rsp_err3, pwrite3, penable3;
  logic [31:0] rsp_rdata3, paddr3, pwdata3;
  logic [2:0] pprot3, psel3;
  logic [3:0] pstrb3;
  int n_vec, n_bad, pen, pulses;

  apb_requester u_dut (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .pprot(pprot), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel), .penable(penable), .prdata_flat(prdata), .pready_vec(pready),
    .pslverr_vec(pslverr)
  );

  apb_requester #(.NUM_SLV(3)) u_dut3 (
    .pclk(pclk), .preset(preset), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .paddr(paddr3), .pwrite(pwrite3), .pprot(pprot3), .pwdata(pwdata3), .pstrb(pstrb3),
    .psel(psel3), .penable(penable3), .prdata_flat(prdata3), .pready_vec(pready3),
    .pslverr_vec(pslverr3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge pclk);
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    preset = 1;
    cmd_valid = 1;
    cmd_valid3 = 0;
    cmd_write = 0;
    cmd_addr = 0;
    cmd_wdata = 0;
    cmd_strb = 0;
    cmd_prot = 0;
    prdata = 0;
    pready = 0;
    pslverr = 0;
    prdata3 = 0;
    pready3 = 0;
    pslverr3 = 0;
    tick;
    tick;
    check("rst_ready", cmd_ready, 0);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_paddr", paddr, 0);
    check("rst_ready3", cmd_ready3, 0);
    preset = 0;
    cmd_valid = 0;
    #1;
    check("idle_ready", cmd_ready, 1);
    // zero-wait write to completer 2
    cmd_addr = 32'h2004;
    cmd_write = 1;
    cmd_wdata = 32'hA5A5_0F0F;
    cmd_strb = 4'b0011;
    cmd_prot = 3'b010;
    pready = 4'hF;
    cmd_valid = 1;
    #1;
    check("w_ready", cmd_ready, 1);
    tick;
    cmd_valid = 0;
    check("w_setup_psel", psel, 4'b0100);
    check("w_setup_penable", penable, 0);
    check("w_pstrb", pstrb, 4'b0011);
    check("w_paddr", paddr, 32'h2004);
    check("w_pwdata", pwdata, 32'hA5A5_0F0F);
    check("w_pprot", pprot, 3'b010);
    check("w_setup_ready", cmd_ready, 0);
    tick;
    check("w_access_penable", penable, 1);
    check("w_access_psel", psel, 4'b0100);
    check("w_access_rsp", rsp_valid, 0);
    tick;
    check("w_rsp_valid", rsp_valid, 1);
    check("w_rsp_err", rsp_err, 0);
    check("w_rsp_rdata", rsp_rdata, 0);
    check("w_done_psel", psel, 0);
    tick;
    check("w_rsp_once", rsp_valid, 0);
    // read with 3 wait states from completer 1; other completers flag errors that must be ignored
    cmd_addr = 32'h1000;
    cmd_write = 0;
    cmd_strb = 4'hF;
    pready = 0;
    pslverr = 4'b1101;
    prdata = {32'h0BAD_0BAD, 32'h0, 32'hDEAD_BEEF, 32'h1234_5678};
    cmd_valid = 1;
    tick;
    cmd_valid = 0;
    check("r_pstrb", pstrb, 0);
    check("r_psel", psel, 4'b0010);
    tick;
    tick;
    tick;
    tick;
    pready = 4'b0010;
    check("r_wait_rsp", rsp_valid, 0);
    check("r_wait_penable", penable, 1);
    tick;
    check("r_rsp_valid", rsp_valid, 1);
    check("r_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("r_rsp_err", rsp_err, 0);
    // back-to-back: read completer 0 then write completer 3
    pready = 4'hF;
    pslverr = 0;
    prdata = {96'h0, 32'h1111_2222};
    cmd_addr = 32'h0000;
    cmd_write = 0;
    cmd_valid = 1;
    tick;
    cmd_addr = 32'h3000;
    cmd_write = 1;
    cmd_wdata = 32'h5555_AAAA;
    cmd_strb = 4'hF;
    #1;
    check("b2b_setup_ready", cmd_ready, 0);
    check("b2b_psel0", psel, 4'b0001);
    tick;
    check("b2b_access_ready", cmd_ready, 1);
    check("b2b_penable0", penable, 1);
    tick;
    cmd_valid = 0;
    check("b2b_psel3", psel, 4'b1000);
    check("b2b_gap_penable", penable, 0);
    check("b2b_rsp1", rsp_valid, 1);
    check("b2b_rdata1", rsp_rdata, 32'h1111_2222);
    check("b2b_pwrite", pwrite, 1);
    check("b2b_pwdata", pwdata, 32'h5555_AAAA);
    tick;
    check("b2b_penable3", penable, 1);
    check("b2b_rsp_gap", rsp_valid, 0);
    tick;
    check("b2b_rsp2", rsp_valid, 1);
    check("b2b_rdata2", rsp_rdata, 0);
    check("b2b_done_psel", psel, 0);
    // timeout with no pready from completer 2
    pready = 0;
    cmd_addr = 32'h2000;
    cmd_write = 0;
    cmd_valid = 1;
    tick;
    cmd_valid = 0;
    pen = 0;
    pulses = 0;
    for (int i = 1; i <= 17; i++) begin
      pen += int'(penable);
      pulses += int'(rsp_valid);
      if (i == 17) begin
        pready = 4'b1011;
        #1;
        check("to_last_ready", cmd_ready, 0);
      end
      tick;
    end
    check("to_penable_cycles", pen, 16);
    check("to_early_rsp", pulses, 0);
    check("to_rsp_valid", rsp_valid, 1);
    check("to_rsp_err", rsp_err, 1);
    check("to_rsp_rdata", rsp_rdata, 0);
    check("to_psel", psel, 0);
    check("to_penable", penable, 0);
    tick;
    // completer error on completer 2
    pready = 4'b0100;
    pslverr = 4'b0100;
    prdata = {32'h0, 32'hCAFE_F00D, 64'h0};
    cmd_valid = 1;
    tick;
    cmd_valid = 0;
    tick;
    tick;
    check("slverr_rsp_valid", rsp_valid, 1);
    check("slverr_rsp_err", rsp_err, 1);
    check("slverr_rsp_rdata", rsp_rdata, 0);
    tick;
    // reset in the middle of an ACCESS
    pready = 0;
    pslverr = 0;
    cmd_addr = 32'h1000;
    cmd_valid = 1;
    tick;
    cmd_valid = 0;
    tick;
    check("mid_penable", penable, 1);
    preset = 1;
    #1;
    check("mid_rst_ready", cmd_ready, 0);
    tick;
    check("mid_psel", psel, 0);
    check("mid_penable_off", penable, 0);
    check("mid_rsp", rsp_valid, 0);
    tick;
    tick;
    preset = 0;
    pready = 4'hF;
    pulses = 0;
    repeat (5) begin
      pulses += int'(rsp_valid);
      tick;
    end
    check("mid_no_rsp", pulses, 0);
    // decode miss on the 3-completer instance
    cmd_addr = 32'h3000;
    cmd_write = 0;
    cmd_valid3 = 1;
    #1;
    check("dm_ready", cmd_ready3, 1);
    tick;
    cmd_valid3 = 0;
    check("dm_rsp_valid", rsp_valid3, 1);
    check("dm_rsp_err", rsp_err3, 1);
    check("dm_rsp_rdata", rsp_rdata3, 0);
    check("dm_psel", psel3, 0);
    check("dm_busy", cmd_ready3, 0);
    tick;
    check("dm_ready_again", cmd_ready3, 1);
    check("dm_rsp_once", rsp_valid3, 0);
    // decode miss accepted back-to-back behind a good transfer
    pready3 = 3'b111;
    cmd_addr = 32'h1000;
    cmd_valid3 = 1;
    tick;
    cmd_addr = 32'h3000;
    tick;
    tick;
    cmd_valid3 = 0;
    check("dm_b2b_rsp1", rsp_valid3, 1);
    check("dm_b2b_err1", rsp_err3, 0);
    check("dm_b2b_psel", psel3, 0);
    tick;
    check("dm_b2b_rsp2", rsp_valid3, 1);
    check("dm_b2b_err2", rsp_err3, 1);
    tick;
    check("dm_b2b_rsp_end", rsp_valid3, 0);
    check("dm_b2b_ready", cmd_ready3, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
